cgra_kernel_sched: RTL and testbench

Kernel launch scheduler for the CGRA PE array. It queues host kernel commands (base address plus iteration count) and replays each command as a sequence of PE-array launches. For every launch it drives a one-cycle start pulse and tracks the array's busy flag, advancing the data base address by a fixed stride between iterations. It sits between the host-side control registers and the Torus array / BRAM interface start/busy handshake, and replaces direct software toggling of the start flag.

---
 rtl/cgra_sched_pkg.sv | 25 ++
 rtl/cgra_kernel_sched_cmd_fifo.sv | 54 +++++
 rtl/cgra_kernel_sched.sv | 144 ++++++++++++++
 tb/tb_cgra_kernel_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_sched_pkg.sv
// Shared types and default parameters for the CGRA kernel launch scheduler.
// Holds the FSM state encoding and the host command bundle.
package cgra_sched_pkg;

    localparam int DEF_AWIDTH         = 32;
    localparam int DEF_CWIDTH         = 16;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_ADDR_STRIDE    = 256;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [DEF_AWIDTH-1:0] base;
        logic [DEF_CWIDTH-1:0] iter;
    } sched_cmd_t;

endpackage

// File: rtl/cgra_kernel_sched_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head.
// Simultaneous push and pop are both honoured.
module sched_cmd_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   push,
    input  logic [W-1:0]           wr_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign full    = (r_count == (PW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rptr];

    always_ff @(posedge Clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cgra_kernel_sched.sv
// Kernel launch scheduler: replays queued host commands as PE-array launches.
// Define CGRA_SCHED_WATCHDOG_EN to enable the busy-handshake watchdog.
module cgra_kernel_sched
    import cgra_sched_pkg::*;
#(
    parameter int AWIDTH      = DEF_AWIDTH,
    parameter int CWIDTH      = DEF_CWIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
`ifdef CGRA_SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic [AWIDTH-1:0] Cmd_Base_Addr,
    input  logic [CWIDTH-1:0] Cmd_Iter,
    output logic              PE_Start,
    output logic [AWIDTH-1:0] PE_Base_Addr,
    input  logic              PE_Array_Busy,
    output logic              Kernel_Done,
    output logic [CWIDTH-1:0] Iter_Count,
    output logic              Sched_Idle,
    output logic              Timeout_Err
);

    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW   = AWIDTH + CWIDTH;

    sched_state_t      r_state;
    logic [AWIDTH-1:0] r_base;
    logic [CWIDTH-1:0] r_remain;
    logic [CWIDTH-1:0] r_iter_cnt;

    logic [DW-1:0]     w_head;
    logic [AWIDTH-1:0] w_head_base;
    logic [CWIDTH-1:0] w_head_iter;
    logic              w_full;
    logic              w_empty;
    logic [CNTW-1:0]   w_count;
    logic              w_pop;
    logic              w_timeout;

    sched_cmd_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push    (Cmd_Valid),
        .wr_data ({Cmd_Base_Addr, Cmd_Iter}),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_head_base  = w_head[DW-1 -: AWIDTH];
    assign w_head_iter  = w_head[CWIDTH-1:0];
    assign w_pop        = (r_state == S_IDLE) && !w_empty;

    assign Cmd_Ready    = !w_full;
    assign PE_Start     = (r_state == S_LAUNCH);
    assign Kernel_Done  = (r_state == S_DONE);
    assign PE_Base_Addr = r_base;
    assign Iter_Count   = r_iter_cnt;
    assign Sched_Idle   = (r_state == S_IDLE) && (w_count == '0);

`ifdef CGRA_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wd;
    logic           r_err;
    logic           w_wd_active;

    assign w_wd_active = (r_state == S_WAIT_BUSY) || (r_state == S_RUN);
    assign w_timeout   = w_wd_active && (r_wd == WDW'(TIMEOUT_CYCLES - 1));
    assign Timeout_Err = r_err;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd <= w_wd_active ? r_wd + WDW'(1) : '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign Timeout_Err = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_remain   <= '0;
            r_iter_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_base     <= w_head_base;
                        r_remain   <= w_head_iter;
                        r_iter_cnt <= '0;
                        // zero-count commands retire through NEXT with no launch
                        r_state    <= (w_head_iter == '0) ? S_NEXT : S_LAUNCH;
                    end
                end
                S_LAUNCH: r_state <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (w_timeout)         r_state <= S_DONE;
                    else if (PE_Array_Busy) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_timeout)          r_state <= S_DONE;
                    else if (!PE_Array_Busy) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_remain == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_iter_cnt <= r_iter_cnt + CWIDTH'(1);
                        r_remain   <= r_remain - CWIDTH'(1);
                        if (r_remain == CWIDTH'(1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_base  <= r_base + AWIDTH'(ADDR_STRIDE);
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_kernel_sched.sv
// Directed scoreboard bench for cgra_kernel_sched.
// Define CGRA_SCHED_WATCHDOG_EN to also exercise the watchdog path.
module tb_cgra_kernel_sched;
    import cgra_sched_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Cmd_Valid = 1'b0;
    logic        Cmd_Ready;
    logic [31:0] Cmd_Base_Addr = '0;
    logic [15:0] Cmd_Iter = '0;
    logic        PE_Start;
    logic [31:0] PE_Base_Addr;
    logic        PE_Array_Busy = 1'b0;
    logic        Kernel_Done;
    logic [15:0] Iter_Count;
    logic        Sched_Idle;
    logic        Timeout_Err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    int start_cnt = 0;
    int busy_cnt = 0;
    int busy_len = 5;
    bit busy_en = 1'b1;
    bit busy_hold = 1'b0;
    int ws;

    logic [31:0] exp_addr[$];
    sched_cmd_t  exp_done[$];

    cgra_kernel_sched #(
        .ADDR_STRIDE    (256)
`ifdef CGRA_SCHED_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Cmd_Valid     (Cmd_Valid),
        .Cmd_Ready     (Cmd_Ready),
        .Cmd_Base_Addr (Cmd_Base_Addr),
        .Cmd_Iter      (Cmd_Iter),
        .PE_Start      (PE_Start),
        .PE_Base_Addr  (PE_Base_Addr),
        .PE_Array_Busy (PE_Array_Busy),
        .Kernel_Done   (Kernel_Done),
        .Iter_Count    (Iter_Count),
        .Sched_Idle    (Sched_Idle),
        .Timeout_Err   (Timeout_Err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PE array model: busy rises with the launch pulse, holds busy_len cycles
    always @(negedge Clk) begin
        if (Rst) busy_cnt = 0;
        else if (PE_Start && busy_en) busy_cnt = busy_len;
        else if (busy_cnt > 0 && !busy_hold) busy_cnt--;
        PE_Array_Busy = busy_hold || (busy_cnt > 0);
    end

    always @(negedge Clk) begin
        if (!Rst && PE_Start) begin
            start_cnt++;
            last_start_cyc = cyc;
            check("start_expected", 64'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0)
                check("start_addr", PE_Base_Addr, exp_addr.pop_front());
        end
        if (!Rst && Kernel_Done) begin
            sched_cmd_t d;
            check("done_expected", 64'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) begin
                d = exp_done.pop_front();
                check("done_iter", Iter_Count, d.iter);
                check("done_addr", PE_Base_Addr, d.base);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] base, input logic [15:0] iter,
                            input int nst, input logic [15:0] dit);
        sched_cmd_t d;
        int n = 0;
        Cmd_Valid     = 1'b1;
        Cmd_Base_Addr = base;
        Cmd_Iter      = iter;
        while (!Cmd_Ready && n < 300) begin
            tick();
            n++;
        end
        check("cmd_accept", Cmd_Ready, 1);
        for (int i = 0; i < nst; i++)
            exp_addr.push_back(base + 32'(i * 256));
        d.base = (nst == 0) ? base : base + 32'((nst - 1) * 256);
        d.iter = dit;
        exp_done.push_back(d);
        tick();
        Cmd_Valid = 1'b0;
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        while (!PE_Start && n < lim) begin
            tick();
            n++;
        end
        check("wait_start", PE_Start, 1);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!Kernel_Done && n < lim) begin
            tick();
            n++;
        end
        check("wait_done", Kernel_Done, 1);
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while (!(Sched_Idle && exp_done.size() == 0) && n < lim) begin
            tick();
            n++;
        end
        check("drain_done_q", exp_done.size(), 0);
        check("drain_addr_q", exp_addr.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (2) tick();
        check("rst_idle", Sched_Idle, 1);
        check("rst_ready", Cmd_Ready, 1);
        check("rst_start", PE_Start, 0);
        check("rst_done", Kernel_Done, 0);
        check("rst_terr", Timeout_Err, 0);
        check("rst_addr", PE_Base_Addr, 0);
        check("rst_iter", Iter_Count, 0);
        Rst = 1'b0;
        repeat (2) tick();
        check("idle_after_rst", Sched_Idle, 1);
        check("idle_start", PE_Start, 0);

        // three iterations, stride-spaced launches
        start_cnt = 0;
        push_cmd(32'h1000, 16'd3, 3, 16'd3);
        tick();
        check("first_start_lat", PE_Start, 1);
        check("first_start_addr", PE_Base_Addr, 32'h1000);
        wait_done(100);
        check("done_after_busy_low", cyc - last_start_cyc, 7);
        check("iter_count_3", Iter_Count, 3);
        check("launches_3", start_cnt, 3);
        tick();
        check("done_one_cycle", Kernel_Done, 0);
        check("iter_hold", Iter_Count, 3);
        check("idle_after_cmd", Sched_Idle, 1);

        // zero iterations: no launch, done two cycles after the pop
        start_cnt = 0;
        push_cmd(32'h40, 16'd0, 0, 16'd0);
        check("zero_pop_cycle", Kernel_Done, 0);
        tick();
        check("zero_p1", Kernel_Done, 0);
        tick();
        check("zero_p2_done", Kernel_Done, 1);
        check("zero_iter", Iter_Count, 0);
        tick();
        check("zero_no_start", start_cnt, 0);

        // queue fills while the array is stalled
        busy_hold = 1'b1;
        push_cmd(32'hA000, 16'd1, 1, 16'd1);
        wait_start(20);
        push_cmd(32'hB000, 16'd2, 2, 16'd2);
        push_cmd(32'hC000, 16'd1, 1, 16'd1);
        push_cmd(32'hD000, 16'd3, 3, 16'd3);
        push_cmd(32'hE000, 16'd1, 1, 16'd1);
        check("full_ready_low", Cmd_Ready, 0);
        check("full_not_idle", Sched_Idle, 0);
        repeat (2) tick();
        check("stall_ready_low", Cmd_Ready, 0);
        busy_hold = 1'b0;
        push_cmd(32'hF000, 16'd2, 2, 16'd2);
        wait_drain(400);

        // address wraps at 2^32
        push_cmd(32'hFFFF_FF00, 16'd2, 2, 16'd2);
        wait_done(100);
        check("wrap_addr", PE_Base_Addr, 32'h0);
        tick();

`ifdef CGRA_SCHED_WATCHDOG_EN
        busy_en = 1'b0;
        push_cmd(32'h7000, 16'd2, 1, 16'd0);
        push_cmd(32'h7100, 16'd1, 1, 16'd0);
        wait_start(20);
        ws = cyc;
        wait_done(60);
        check("wd_latency", cyc - ws, 17);
        check("wd_err", Timeout_Err, 1);
        wait_start(20);
        check("wd_next_addr", PE_Base_Addr, 32'h7100);
        wait_done(60);
        check("wd_err_sticky", Timeout_Err, 1);
        tick();
        busy_en = 1'b1;
`else
        check("terr_tied", Timeout_Err, 0);
`endif

        // reset in the middle of a run flushes everything
        push_cmd(32'h5000, 16'd4, 4, 16'd4);
        wait_start(20);
        repeat (3) tick();
        push_cmd(32'h6000, 16'd1, 1, 16'd1);
        check("pre_rst_busy", Sched_Idle, 0);
        Rst = 1'b1;
        #1;
        exp_addr.delete();
        exp_done.delete();
        check("mid_rst_idle", Sched_Idle, 1);
        check("mid_rst_ready", Cmd_Ready, 1);
        check("mid_rst_start", PE_Start, 0);
        check("mid_rst_done", Kernel_Done, 0);
        check("mid_rst_addr", PE_Base_Addr, 0);
        check("mid_rst_iter", Iter_Count, 0);
        check("mid_rst_terr", Timeout_Err, 0);
        repeat (2) tick();
        start_cnt = 0;
        Rst = 1'b0;
        repeat (20) tick();
        check("post_rst_no_start", start_cnt, 0);
        check("post_rst_idle", Sched_Idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
